pix_line_buf: RTL and testbench

PIX_LINE_BUF -- requirements
Module: pix_line_buf

---
 rtl/pix_line_buf.sv | 226 ++++++++++++++++++++++
 tb/tb_pix_line_buf.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pix_line_buf.sv
// -----------------------------------------------------------------------------
// pix_line_buf
//
// Ping-pong line buffer for an RGB565 camera path. Pixels of the line being
// captured are written at random addresses into the write bank. On the end of
// line pulse the write bank is handed to the reader and the banks swap. The
// reader streams the line out in address order over a valid/ready handshake.
// A completed line that finds the read bank still occupied is dropped.
//
// Build option:
//   PIX_LINE_BUF_DROP_STAT_EN  when defined, DropCnt is an 8-bit saturating
//                              count of dropped lines; otherwise DropCnt is 0.
//
// Parameters:
//   LINE_PIX  pixels per streamed line (1..1024)
//   CNT_W     width of LineCnt
//
// Ports:
//   CLK         sole clock, rising edge
//   RST         synchronous active-high reset
//   LineWrAddr  pixel address within the line being captured
//   LineWrData  RGB565 pixel
//   LineWrEn    write strobe for LineWrAddr/LineWrData
//   HsyncEdge   one-cycle pulse, end of captured line
//   VsyncEdge   one-cycle pulse, start of frame
//   OutData     streamed pixel
//   OutValid    OutData valid
//   OutReady    consumer accepts the pixel (transfer on OutValid & OutReady)
//   OutSof      first pixel of the first line of a frame
//   OutEol      last pixel of a line
//   LineCnt     lines handed off since the last VsyncEdge, saturating
//   Overflow    sticky, a completed line was dropped
//   DropCnt     dropped-line count (0 unless PIX_LINE_BUF_DROP_STAT_EN)
// -----------------------------------------------------------------------------
module pix_line_buf #(
  parameter int LINE_PIX = 640,
  parameter int CNT_W    = 9
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [9:0]       LineWrAddr,
  input  logic [15:0]      LineWrData,
  input  logic             LineWrEn,
  input  logic             HsyncEdge,
  input  logic             VsyncEdge,
  output logic [15:0]      OutData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             OutSof,
  output logic             OutEol,
  output logic [CNT_W-1:0] LineCnt,
  output logic             Overflow,
  output logic [7:0]       DropCnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_STREAM
  } rd_state_t;

  localparam logic [9:0]       LAST_PIX = 10'(LINE_PIX - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Pixel storage, one array per bank
  logic [15:0] r_bank0 [1024];
  logic [15:0] r_bank1 [1024];

  // Bank bookkeeping
  logic             r_wr_bank;      // bank currently receiving pixels
  logic [1:0]       r_full;         // per bank: holds a line not yet streamed
  logic [1:0]       r_line_sof;     // per bank: line is the first of a frame
  logic             r_written;      // write bank has received a pixel
  logic             r_sof_pending;  // next handed-off line starts a frame
  logic [CNT_W-1:0] r_line_cnt;
  logic             r_overflow;

  // Reader
  rd_state_t   r_state;
  logic [9:0]  r_pix;               // index of the pixel on OutData
  logic [15:0] r_out_data;
  logic        r_out_valid;
  logic        r_out_sof;
  logic        r_out_eol;

  logic        w_rd_bank;
  logic        w_wr_ok;
  logic        w_accept;
  logic        w_last_accept;
  logic        w_rd_free;
  logic        w_line_done;
  logic        w_swap;
  logic        w_drop;
  logic [9:0]  w_nxt_pix;
  logic [9:0]  w_rd_addr;
  logic [15:0] w_rd_word;

  assign w_rd_bank     = ~r_wr_bank;
  assign w_wr_ok       = LineWrEn && ({1'b0, LineWrAddr} < 11'(LINE_PIX));
  assign w_accept      = r_out_valid && OutReady;
  assign w_last_accept = w_accept && r_out_eol;

  // The read bank counts as free in the cycle its last pixel is taken, so a
  // line can be handed off without waiting a cycle for the flag to drop.
  assign w_rd_free     = !r_full[w_rd_bank] || w_last_accept;

  // VsyncEdge overrides HsyncEdge: the partial/complete line is discarded.
  assign w_line_done   = HsyncEdge && !VsyncEdge && r_written;
  assign w_swap        = w_line_done && w_rd_free;
  assign w_drop        = w_line_done && !w_rd_free;

  // FETCH reads pixel 0; while streaming, prefetch the pixel after the one
  // being presented so an accept can load it without a bubble.
  assign w_nxt_pix     = r_pix + 10'd1;
  assign w_rd_addr     = (r_state == ST_STREAM) ? w_nxt_pix : 10'd0;
  assign w_rd_word     = w_rd_bank ? r_bank1[w_rd_addr] : r_bank0[w_rd_addr];

  // NOTE: pixel storage has no reset; clearing RAM is neither needed (the
  // full flags gate every read) nor possible for block RAM in one cycle.
  always_ff @(posedge CLK) begin
    if (w_wr_ok) begin
      if (r_wr_bank) r_bank1[LineWrAddr] <= LineWrData;
      else           r_bank0[LineWrAddr] <= LineWrData;
    end
  end

  // Bank handoff, frame tracking and error status
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_bank     <= 1'b0;
      r_full        <= 2'b00;
      r_line_sof    <= 2'b00;
      r_written     <= 1'b0;
      r_sof_pending <= 1'b1;
      r_line_cnt    <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_wr_ok) r_written <= 1'b1;
      if (w_last_accept) r_full[w_rd_bank] <= 1'b0;

      if (VsyncEdge) begin
        r_written     <= 1'b0;
        r_line_cnt    <= '0;
        r_sof_pending <= 1'b1;
      end else if (w_swap) begin
        r_wr_bank             <= ~r_wr_bank;
        r_full[r_wr_bank]     <= 1'b1;
        r_line_sof[r_wr_bank] <= r_sof_pending;
        r_sof_pending         <= 1'b0;
        r_written             <= 1'b0;
        if (r_line_cnt != CNT_MAX) r_line_cnt <= r_line_cnt + 1'b1;
      end else if (w_drop) begin
        r_written  <= 1'b0;
        r_overflow <= 1'b1;
      end
    end
  end

  // Reader FSM with registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_pix       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eol   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Leaving on the swap itself puts pixel 0 out two cycles later.
          if (r_full[w_rd_bank] || w_swap) r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          r_out_data  <= w_rd_word;
          r_out_valid <= 1'b1;
          r_out_sof   <= r_line_sof[w_rd_bank];
          r_out_eol   <= (LAST_PIX == 10'd0);
          r_pix       <= '0;
          r_state     <= ST_STREAM;
        end
        ST_STREAM: begin
          if (w_accept) begin
            if (r_out_eol) begin
              r_out_valid <= 1'b0;
              r_out_sof   <= 1'b0;
              r_out_eol   <= 1'b0;
              // A line handed off in this same cycle is fetched directly so
              // it keeps the same two-cycle start latency as from idle.
              r_state     <= w_swap ? ST_FETCH : ST_IDLE;
            end else begin
              r_out_data <= w_rd_word;
              r_pix      <= w_nxt_pix;
              r_out_sof  <= 1'b0;
              r_out_eol  <= (w_nxt_pix == LAST_PIX);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef PIX_LINE_BUF_DROP_STAT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge CLK) begin
    if (RST)                               r_drop_cnt <= 8'd0;
    else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign DropCnt = r_drop_cnt;
`else
  assign DropCnt = 8'd0;
`endif

  assign OutData  = r_out_data;
  assign OutValid = r_out_valid;
  assign OutSof   = r_out_sof;
  assign OutEol   = r_out_eol;
  assign LineCnt  = r_line_cnt;
  assign Overflow = r_overflow;

endmodule

// File: tb/tb_pix_line_buf.sv
// -----------------------------------------------------------------------------
// tb_pix_line_buf
//
// Self-checking bench for pix_line_buf with an 8-pixel line and a 3-bit line
// counter. A line-level reference model (captured line, read-slot occupancy,
// frame state) predicts the handed-off lines as a pixel queue and the status
// outputs; a consumer monitor scores every accepted pixel against it.
// -----------------------------------------------------------------------------
module tb_pix_line_buf;

  localparam int LP      = 8;
  localparam int CW      = 3;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic          CLK        = 1'b0;
  logic          RST        = 1'b1;
  logic [9:0]    LineWrAddr = '0;
  logic [15:0]   LineWrData = '0;
  logic          LineWrEn   = 1'b0;
  logic          HsyncEdge  = 1'b0;
  logic          VsyncEdge  = 1'b0;
  logic          OutReady   = 1'b0;
  logic [15:0]   OutData;
  logic          OutValid;
  logic          OutSof;
  logic          OutEol;
  logic [CW-1:0] LineCnt;
  logic          Overflow;
  logic [7:0]    DropCnt;

  pix_line_buf #(.LINE_PIX(LP), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .LineWrAddr(LineWrAddr), .LineWrData(LineWrData), .LineWrEn(LineWrEn),
    .HsyncEdge(HsyncEdge), .VsyncEdge(VsyncEdge),
    .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
    .OutSof(OutSof), .OutEol(OutEol),
    .LineCnt(LineCnt), .Overflow(Overflow), .DropCnt(DropCnt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eol;
  } pix_t;

  pix_t        exp_q[$];
  logic [15:0] stim [LP];

  // Reference model state (values expected after the most recent edge)
  logic [15:0] m_line [LP];
  bit m_written   = 1'b0;
  bit m_read_full = 1'b0;
  bit m_sof_pend  = 1'b1;
  bit m_overflow  = 1'b0;
  int m_line_cnt  = 0;
  int m_drop_cnt  = 0;
  int m_acc       = 0;

  // Previous-cycle handshake snapshot for stability / bubble checks
  bit          p_valid = 1'b0;
  bit          p_ready = 1'b0;
  bit          p_eol   = 1'b0;
  bit          p_sof   = 1'b0;
  logic [15:0] p_data  = '0;

  // Consumer ready: 0 = hold rdy_val, 1 = pattern 1,0,0,..., 2 = random
  int rdy_mode = 0;
  bit rdy_val  = 1'b0;
  int rdy_idx  = 0;

  always @(posedge CLK) begin
    #1;
    case (rdy_mode)
      0:       OutReady = rdy_val;
      1: begin OutReady = (rdy_idx % 3 == 0); rdy_idx++; end
      default: OutReady = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor + model, evaluated mid-cycle while all inputs are stable
  always @(negedge CLK) begin
    pix_t e;
    bit   release_line;
    bit   old_w;
    bit   wr_ok;

    n_checks++;
    if (LineCnt !== CW'(m_line_cnt)) begin
      n_fail++; $display("FAIL linecnt: got %0d want %0d", LineCnt, m_line_cnt);
    end
    n_checks++;
    if (Overflow !== m_overflow) begin
      n_fail++; $display("FAIL overflow: got %b want %b", Overflow, m_overflow);
    end
    n_checks++;
    if (DropCnt !== 8'(m_drop_cnt)) begin
      n_fail++; $display("FAIL dropcnt: got %0d want %0d", DropCnt, m_drop_cnt);
    end

    if (!RST) begin
      if (p_valid && !p_ready) begin
        n_checks++;
        if ({OutValid, OutData, OutSof, OutEol} !== {1'b1, p_data, p_sof, p_eol}) begin
          n_fail++;
          $display("FAIL stall_stable: got v=%b d=%h s=%b e=%b want v=1 d=%h s=%b e=%b",
                   OutValid, OutData, OutSof, OutEol, p_data, p_sof, p_eol);
        end
      end
      if (p_valid && p_ready && !p_eol) begin
        n_checks++;
        if (OutValid !== 1'b1) begin
          n_fail++; $display("FAIL no_bubble: got valid=%b want 1", OutValid);
        end
      end
      if (OutValid && OutReady) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL unexpected_pixel: got d=%h want none", OutData);
        end else begin
          e = exp_q.pop_front();
          if ({OutData, OutSof, OutEol} !== {e.data, e.sof, e.eol}) begin
            n_fail++;
            $display("FAIL pixel: got d=%h s=%b e=%b want d=%h s=%b e=%b",
                     OutData, OutSof, OutEol, e.data, e.sof, e.eol);
          end
        end
      end
    end

    p_valid = !RST && (OutValid === 1'b1);
    p_ready = (OutReady === 1'b1);
    p_eol   = (OutEol === 1'b1);
    p_sof   = (OutSof === 1'b1);
    p_data  = OutData;

    // Predict the state after the coming edge
    if (RST) begin
      m_written = 0; m_read_full = 0; m_sof_pend = 1; m_overflow = 0;
      m_line_cnt = 0; m_drop_cnt = 0; m_acc = 0;
      exp_q.delete();
    end else begin
      release_line = 1'b0;
      old_w        = m_written;
      if (OutValid && OutReady) begin
        m_acc++;
        if (m_acc == LP) begin release_line = 1'b1; m_acc = 0; end
      end
      wr_ok = LineWrEn && (int'(LineWrAddr) < LP);
      if (wr_ok) m_line[int'(LineWrAddr)] = LineWrData;
      if (release_line) m_read_full = 1'b0;

      if (VsyncEdge) begin
        m_written = 0; m_line_cnt = 0; m_sof_pend = 1;
      end else if (HsyncEdge && old_w) begin
        if (!m_read_full) begin
          for (int i = 0; i < LP; i++)
            exp_q.push_back('{data: m_line[i], sof: (i == 0) && m_sof_pend,
                              eol: (i == LP - 1)});
          m_read_full = 1'b1;
          m_sof_pend  = 1'b0;
          if (m_line_cnt < CNT_SAT) m_line_cnt++;
        end else begin
          m_overflow = 1'b1;
`ifdef PIX_LINE_BUF_DROP_STAT_EN
          if (m_drop_cnt < 255) m_drop_cnt++;
`endif
        end
        m_written = 1'b0;
      end else if (wr_ok) begin
        m_written = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < LP; i++) stim[i] = 16'($urandom);
  endtask

  task automatic write_line(input int n, input bit do_hsync);
    for (int i = 0; i < n; i++) begin
      LineWrEn = 1'b1; LineWrAddr = 10'(i); LineWrData = stim[i];
      tick();
    end
    LineWrEn = 1'b0;
    if (do_hsync) begin
      HsyncEdge = 1'b1; tick(); HsyncEdge = 1'b0;
    end
  endtask

  task automatic pulse_vsync();
    VsyncEdge = 1'b1; tick(); VsyncEdge = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || OutValid) && n < budget) begin
      tick(); n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pixels left want 0", exp_q.size());
    end
  endtask

  task automatic idle_quiet(input int cycles, input string name);
    for (int i = 0; i < cycles; i++) tick();
    n_checks++;
    if (OutValid !== 1'b0) begin
      n_fail++; $display("FAIL %s: got valid=%b want 0", name, OutValid);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if ({OutValid, OutSof, OutEol, OutData, LineCnt, Overflow, DropCnt} !==
        {1'b0, 1'b0, 1'b0, 16'h0, CW'(0), 1'b0, 8'h0}) begin
      n_fail++;
      $display("FAIL %s: got v=%b s=%b e=%b d=%h lc=%0d ov=%b dc=%0d want all 0",
               name, OutValid, OutSof, OutEol, OutData, LineCnt, Overflow, DropCnt);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; tick(); tick();
    check_reset_outputs("reset_state");
    RST = 1'b0; tick();
    idle_quiet(4, "idle_after_reset");
  endtask

  task automatic test_single_line();
    rdy_mode = 0; rdy_val = 1'b1; tick();
    for (int i = 0; i < LP; i++) stim[i] = 16'h1000 + 16'(i);
    write_line(LP, 1'b0);
    HsyncEdge = 1'b1; tick(); HsyncEdge = 1'b0;
    n_checks++;
    if ({OutValid, LineCnt} !== {1'b0, CW'(1)}) begin
      n_fail++; $display("FAIL swap_plus1: got v=%b lc=%0d want v=0 lc=1", OutValid, LineCnt);
    end
    tick();
    n_checks++;
    if ({OutValid, OutData, OutSof} !== {1'b1, 16'h1000, 1'b1}) begin
      n_fail++;
      $display("FAIL swap_plus2: got v=%b d=%h s=%b want v=1 d=1000 s=1", OutValid, OutData, OutSof);
    end
    wait_drain(40);
  endtask

  task automatic test_backpressure();
    rdy_mode = 1; rdy_idx = 0;
    fill_random();
    write_line(LP, 1'b1);
    wait_drain(100);
    rdy_mode = 0;
  endtask

  task automatic test_overflow();
    rdy_mode = 0; rdy_val = 1'b0; tick();
    fill_random(); write_line(LP, 1'b1);
    fill_random(); write_line(LP, 1'b1);
    tick();
    n_checks++;
    if (Overflow !== 1'b1) begin
      n_fail++; $display("FAIL overflow_set: got %b want 1", Overflow);
    end
    n_checks++;
`ifdef PIX_LINE_BUF_DROP_STAT_EN
    if (DropCnt !== 8'd1) begin
      n_fail++; $display("FAIL dropcnt_one: got %0d want 1", DropCnt);
    end
`else
    if (DropCnt !== 8'd0) begin
      n_fail++; $display("FAIL dropcnt_off: got %0d want 0", DropCnt);
    end
`endif
    rdy_val = 1'b1;
    wait_drain(60);
    idle_quiet(20, "only_line_a");
  endtask

  task automatic test_frame();
    rdy_mode = 2;
    pulse_vsync();
    for (int l = 0; l < 3; l++) begin
      fill_random(); write_line(LP, 1'b1); wait_drain(100);
    end
    n_checks++;
    if (LineCnt !== CW'(3)) begin
      n_fail++; $display("FAIL frame_linecnt: got %0d want 3", LineCnt);
    end
    fill_random(); write_line(LP / 2, 1'b0);
    pulse_vsync();
    HsyncEdge = 1'b1; tick(); HsyncEdge = 1'b0;
    n_checks++;
    if (LineCnt !== CW'(0)) begin
      n_fail++; $display("FAIL vsync_linecnt: got %0d want 0", LineCnt);
    end
    idle_quiet(12, "partial_discarded");
    rdy_mode = 0;
  endtask

  task automatic test_linecnt_sat();
    rdy_mode = 0; rdy_val = 1'b1;
    pulse_vsync();
    for (int l = 0; l < CNT_SAT + 2; l++) begin
      fill_random(); write_line(LP, 1'b1); wait_drain(40);
    end
    n_checks++;
    if (LineCnt !== CW'(CNT_SAT)) begin
      n_fail++; $display("FAIL linecnt_sat: got %0d want %0d", LineCnt, CNT_SAT);
    end
  endtask

  task automatic test_edge_cases();
    rdy_mode = 0; rdy_val = 1'b1;
    fill_random(); write_line(LP, 1'b0);
    HsyncEdge = 1'b1; VsyncEdge = 1'b1; tick();
    HsyncEdge = 1'b0; VsyncEdge = 1'b0;
    idle_quiet(6, "hv_no_swap");
    n_checks++;
    if (LineCnt !== CW'(0)) begin
      n_fail++; $display("FAIL hv_linecnt: got %0d want 0", LineCnt);
    end
    LineWrEn = 1'b1; LineWrAddr = 10'd900; LineWrData = 16'hBEEF; tick();
    LineWrAddr = 10'(LP); tick();
    LineWrEn = 1'b0;
    HsyncEdge = 1'b1; tick(); HsyncEdge = 1'b0;
    idle_quiet(6, "oob_write_ignored");
    n_checks++;
    if (LineCnt !== CW'(0)) begin
      n_fail++; $display("FAIL oob_linecnt: got %0d want 0", LineCnt);
    end
    fill_random(); write_line(LP, 1'b1); wait_drain(40);
    n_checks++;
    if (LineCnt !== CW'(1)) begin
      n_fail++; $display("FAIL after_edge_linecnt: got %0d want 1", LineCnt);
    end
  endtask

  task automatic test_reset_mid_stream();
    rdy_mode = 0; rdy_val = 1'b1;
    fill_random(); write_line(LP, 1'b1);
    tick(); tick(); tick();
    n_checks++;
    if (OutValid !== 1'b1) begin
      n_fail++; $display("FAIL mid_stream_active: got valid=%b want 1", OutValid);
    end
    RST = 1'b1; tick(); RST = 1'b0;
    check_reset_outputs("reset_mid_stream");
    idle_quiet(12, "aborted_line_gone");
  endtask

  task automatic test_back_to_back();
    rdy_mode = 0; rdy_val = 1'b1; tick();
    for (int l = 0; l < 4; l++) begin
      fill_random(); write_line(LP, 1'b1);
    end
    wait_drain(60);
    n_checks++;
    if ({Overflow, LineCnt} !== {1'b0, CW'(4)}) begin
      n_fail++; $display("FAIL back_to_back: got ov=%b lc=%0d want ov=0 lc=4", Overflow, LineCnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_backpressure();
    test_overflow();
    test_frame();
    test_linecnt_sat();
    test_edge_cases();
    test_reset_mid_stream();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL leftover_pixels: got %0d want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit");
  end

endmodule
